rle_stream_arbiter: RTL and testbench
=====================================

# rle_stream_arbiter

Round-robin arbiter and sequencer that shares one RLE decompressor between N serial compressed-bit sources. It sits in the decompressor's serial-output clock domain, in front of the decompressor's serial input. Each source holds one grant until its end-of-stream bit is accepted. The arbiter then enforces a drain gap, reports the decompressed bit count for that stream and re-arbitrates.

## Interface
- N, 4, number of requesting channels (1..16)
- GAP, 2, idle cycles after a stream's last bit before re-arbitration (0..255)
- CW, 16, width of the output-bit counter
- sclk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  N  channel i has a compressed bit available on serIn[i]
- serIn  in  N  compressed bit per channel
- last  in  N  serIn[i] is the final bit of channel i's stream
- ack  out  N  one-hot, bit of channel i consumed this cycle
- gnt  out  N  one-hot registered grant, 0 when no grant
- curCh  out  clog2(N) (min 1)  index of granted or last-granted channel
- stackFull  in  1  decompressor back-pressure
- bitValid  in  1  decompressor produced one output bit this cycle
- decIn  out  1  serial bit to decompressor
- decInValid  out  1  decIn is valid and accepted this cycle
- busy  out  1  state is not IDLE
- outCount  out  CW  bitValid pulses counted for the current or last stream
- done  out  1  one-cycle pulse at stream completion

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE with req != 0:
  - Pick the first i with req[i]=1, searching from pointer p upward and wrapping mod N.
  - Next cycle: gnt=onehot(i), curCh=i, outCount=0, state STREAM.
  - On acceptance of the grant, p becomes (i+1) mod N.
- STREAM, combinational, with g the granted index:
  - decInValid = req[g] & ~stackFull.
  - ack[g] = decInValid; all other ack bits are 0.
  - decIn = serIn[g].
- STREAM stall: req[g]=0 holds the grant; there is no timeout and no abort.
- Ack together with last[g]:
  - GAP>0: go to DRAIN next cycle, gnt=0, load gap counter with GAP.
  - GAP=0: go straight to IDLE.
- DRAIN: decrement the gap counter each cycle. When it reaches 1, go to IDLE next cycle.
- done: registered, high for exactly the first IDLE cycle after STREAM or DRAIN.
- outCount:
  - Increments on bitValid only in STREAM or DRAIN.
  - Saturates at 2^CW-1.
  - Holds its value in IDLE until the next grant.
- stackFull with last high: the bit is not consumed. The stream continues until last is actually acked.
- A req on the granted channel is never dropped. Requests from other channels wait; there is no preemption.
- N=1: p stays 0. Back-to-back streams are separated only by the GAP/IDLE cycles.
- rst low, at any time, asynchronous:
  - Outputs: state IDLE, gnt=0, ack=0, decInValid=0, decIn=0, busy=0, done=0, outCount=0, curCh=0.
  - Internal: p=0, gap counter=0.
  - A partially sent stream is discarded.

## Timing
- Req-to-grant latency: 1 cycle. req seen in IDLE on cycle t gives gnt on t+1, and the first ack is possible on t+1.
- Throughput: 1 bit/cycle while req[g]=1 and stackFull=0.
- Last ack on cycle t: gnt=0 on t+1.
  - GAP>0: DRAIN on t+1..t+GAP, IDLE and done on t+GAP+1. Earliest next grant is t+GAP+2.
  - GAP=0: IDLE and done on t+1. Earliest next grant is t+2.
- busy is high from the grant cycle through the last DRAIN cycle.
- ack, decIn and decInValid are combinational from req, serIn, stackFull and the registered state. All other outputs are registered.

## Test plan
- Reset: drive rst low mid-run with req=4'b1111 -> all outputs 0 immediately (before the next sclk edge); after release with req=0, gnt stays 0 and busy=0.
- Single stream: req[2]=1 with 5 bits 1,0,1,1,0, last on bit 5, stackFull=0, GAP=2 -> gnt=4'b0100 one cycle after req, ack[2] high for 5 consecutive cycles, decIn sequence 10110, DRAIN for 2 cycles, done pulse on the third cycle after the last ack.
- Round-robin: req=4'b1111 throughout, each channel sends 3 bits -> grant order 0,1,2,3,0, each grant lasting 3 STREAM cycles, with 4 done pulses before the second grant to channel 0.
- Back-pressure: stackFull high for 4 cycles in mid-stream, including the cycle last is presented -> ack=0 and decInValid=0 for those cycles; last is consumed on the first cycle stackFull=0, and DRAIN starts the following cycle.
- Counter: 7 bitValid pulses spread across STREAM and DRAIN, plus 2 pulses in IDLE -> outCount=7 at done and held in IDLE. With CW=3 and 10 pulses -> outCount saturates at 7.
- Stall and idle gap: with GAP=0, req[1] drops for 3 cycles mid-stream -> gnt stays 4'b0010 and no other channel is granted; after last, done fires on the next cycle and a pending req[3] is granted one cycle later.

Source files
------------

// File: rtl/rle_stream_arbiter.sv
// Round-robin sequencer sharing one serial RLE decompressor between N compressed-bit sources.
// A grant is held until the stream's last bit is accepted, then a drain gap runs before re-arbitration.
module rle_stream_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned GAP = 2,
  parameter int unsigned CW  = 16
) (
  input  logic                                 sclk,
  input  logic                                 rst,
  input  logic [N-1:0]                         req,
  input  logic [N-1:0]                         serIn,
  input  logic [N-1:0]                         last,
  output logic [N-1:0]                         ack,
  output logic [N-1:0]                         gnt,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0]   curCh,
  input  logic                                 stackFull,
  input  logic                                 bitValid,
  output logic                                 decIn,
  output logic                                 decInValid,
  output logic                                 busy,
  output logic [CW-1:0]                        outCount,
  output logic                                 done
);

  localparam int unsigned CHW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GW  = 8;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t           state;
  logic [CHW-1:0]   ptr;
  logic [GW-1:0]    gap_cnt;

  logic [CHW-1:0]   sel_c;
  logic             found_c;
  logic             last_c;
  logic             cnt_max_c;
  int unsigned      best_d_c;
  int unsigned      dist_c;

  // Nearest requester at or after the round-robin pointer, wrapping mod N.
  always_comb begin
    sel_c    = '0;
    best_d_c = N;
    dist_c   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      dist_c = (i + N - 32'(ptr)) % N;
      if (req[i] && (dist_c < best_d_c)) begin
        best_d_c = dist_c;
        sel_c    = CHW'(i);
      end
    end
    found_c = (best_d_c < N);
  end

  // Handshake toward the granted source and the decompressor; gnt is one-hot or zero.
  always_comb begin
    decInValid = (state == STREAM) && (|(req & gnt)) && !stackFull;
    ack        = decInValid ? gnt : '0;
    decIn      = (state == STREAM) && (|(serIn & gnt));
    last_c     = |(last & gnt);
    cnt_max_c  = (outCount == {CW{1'b1}});
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gap_cnt  <= '0;
      gnt      <= '0;
      curCh    <= '0;
      busy     <= 1'b0;
      outCount <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (found_c) begin
            state    <= STREAM;
            busy     <= 1'b1;
            gnt      <= N'(1) << sel_c;
            curCh    <= sel_c;
            outCount <= '0;
            ptr      <= CHW'((32'(sel_c) + 1) % N);
          end
        end
        STREAM: begin
          if (bitValid && !cnt_max_c) outCount <= outCount + CW'(1);
          if (decInValid && last_c) begin
            gnt <= '0;
            if (GAP > 0) begin
              state   <= DRAIN;
              gap_cnt <= GW'(GAP);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bitValid && !cnt_max_c) outCount <= outCount + CW'(1);
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_stream_arbiter.sv
// Randomized scoreboard bench for rle_stream_arbiter: a stream-level model predicts every cycle's
// outputs and every accepted bit; a separate monitor pops and compares what the DUT presents.
module tb_rle_stream_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned GAP  = 2;
  localparam int unsigned CW   = 4;
  localparam int unsigned CHW  = 2;
  localparam int unsigned MAXL = 12;
  localparam int          CMAX = (1 << CW) - 1;
  localparam int unsigned SW   = 1 + N + CHW + CW + 1 + N + 1;

  logic          sclk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, serIn, last, ack, gnt;
  logic [CHW-1:0] curCh;
  logic          stackFull, bitValid, decIn, decInValid, busy, done;
  logic [CW-1:0] outCount;

  rle_stream_arbiter #(.N(N), .GAP(GAP), .CW(CW)) dut (
    .sclk(sclk), .rst(rst), .req(req), .serIn(serIn), .last(last), .ack(ack), .gnt(gnt),
    .curCh(curCh), .stackFull(stackFull), .bitValid(bitValid), .decIn(decIn),
    .decInValid(decInValid), .busy(busy), .outCount(outCount), .done(done)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [SW-1:0]  exp_status[$];
  logic [N:0]     exp_bits[$];

  // Model of the arbiter in stream terms: owner channel, remaining drain cycles, rr pointer.
  int m_owner, m_gap, m_cnt, m_rr, m_cur;
  bit m_done;

  // Sources: each channel may hold one pending compressed stream.
  bit sbits[N][MAXL];
  int slen[N];
  int spos[N];

  function automatic logic [SW-1:0] pk(input logic b, input logic [N-1:0] g, input logic [CHW-1:0] c,
                                       input logic [CW-1:0] n, input logic d, input logic [N-1:0] a,
                                       input logic v);
    return {b, g, c, n, d, a, v};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_cnt = 0; m_rr = 0; m_cur = 0; m_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      slen[i] = 0;
      spos[i] = 0;
    end
  endtask

  task automatic do_cycle(input bit quiet);
    logic [N-1:0] req_v, ser_v, last_v, gv;
    bit sf, bv, acc, lastbit, done_nx, found;
    int ch, idx;
    @(negedge sclk);
    for (int i = 0; i < N; i++) begin
      if (slen[i] == 0 && !quiet && $urandom_range(0, 3) == 0) begin
        slen[i] = $urandom_range(1, MAXL);
        spos[i] = 0;
        for (int k = 0; k < MAXL; k++) sbits[i][k] = 1'($urandom);
      end
    end
    for (int i = 0; i < N; i++) begin
      req_v[i]  = !quiet && (slen[i] > 0) && ($urandom_range(0, 6) != 0);
      ser_v[i]  = (slen[i] > 0) ? sbits[i][spos[i]] : 1'($urandom);
      last_v[i] = (slen[i] > 0) ? (spos[i] == slen[i] - 1) : 1'($urandom);
    end
    sf = ($urandom_range(0, 4) == 0);
    bv = ($urandom_range(0, 9) < 7);
    req = req_v; serIn = ser_v; last = last_v; stackFull = sf; bitValid = bv;

    gv  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    acc = (|(req_v & gv)) && !sf;
    exp_status.push_back(pk((m_owner >= 0) || (m_gap > 0), gv, CHW'(m_cur), CW'(m_cnt), m_done,
                            acc ? gv : '0, acc));
    if (acc) exp_bits.push_back({gv, |(ser_v & gv)});

    done_nx = 1'b0;
    if (m_owner >= 0) begin
      if (bv) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (acc) begin
        ch      = m_owner;
        lastbit = (spos[ch] == slen[ch] - 1);
        spos[ch]++;
        if (lastbit) begin
          slen[ch] = 0;
          m_owner  = -1;
          if (GAP > 0) m_gap = GAP;
          else done_nx = 1'b1;
        end
      end
    end else if (m_gap > 0) begin
      if (bv) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      m_gap--;
      if (m_gap == 0) done_nx = 1'b1;
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!found && req_v[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_cur   = idx;
          m_cnt   = 0;
          m_rr    = (idx + 1) % N;
        end
      end
    end
    m_done = done_nx;
    chk_en = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    logic [SW+1:0] act;
    act = {gnt, ack, decInValid, decIn, busy, done, outCount, curCh};
    n_cmp++;
    if (act !== '0) begin
      n_bad++;
      $display("FAIL %s: outputs under reset got %h, required 0", tag, act);
    end
  endtask

  // Monitor: every checked cycle pops one status record; every accepted bit pops one bit record.
  always @(negedge sclk) begin
    logic [SW-1:0] act, e;
    logic [N:0]    ab, eb;
    #2;
    if (chk_en) begin
      act = pk(busy, gnt, curCh, outCount, done, ack, decInValid);
      n_cmp++;
      if (exp_status.size() == 0) begin
        n_bad++;
        $display("FAIL status @%0t: got %h, no record expected", $time, act);
      end else begin
        e = exp_status.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL status @%0t busy/gnt/ch/cnt/done/ack/dv: got %h required %h", $time, act, e);
        end
      end
      if (decInValid === 1'b1) begin
        ab = {ack, decIn};
        n_cmp++;
        if (exp_bits.size() == 0) begin
          n_bad++;
          $display("FAIL bit @%0t: got ack/decIn %h, no accepted bit expected", $time, ab);
        end else begin
          eb = exp_bits.pop_front();
          if (ab !== eb) begin
            n_bad++;
            $display("FAIL bit @%0t ack/decIn: got %h required %h", $time, ab, eb);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0; req = '0; serIn = '0; last = '0; stackFull = 1'b0; bitValid = 1'b0;
    model_reset();
    #3;
    check_zero("power_on_reset");
    repeat (2) @(negedge sclk);
    rst = 1'b1;

    for (int c = 0; c < 1500; c++) do_cycle(1'b0);

    // Asynchronous reset mid-run with every channel requesting.
    @(negedge sclk);
    chk_en = 1'b0;
    req = '1;
    #1 rst = 1'b0;
    #1 check_zero("midrun_reset");
    req = '0;
    exp_status.delete();
    exp_bits.delete();
    model_reset();
    repeat (2) @(negedge sclk);
    check_zero("reset_hold");
    rst = 1'b1;
    for (int c = 0; c < 4; c++) do_cycle(1'b1);

    for (int c = 0; c < 1500; c++) do_cycle(1'b0);

    @(negedge sclk);
    chk_en = 1'b0;
    #4;
    n_cmp++;
    if (exp_status.size() != 0 || exp_bits.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queues: leftover status %0d bits %0d, required 0 0",
               exp_status.size(), exp_bits.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
